// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and constants for the TPU control sequencer.
//   tpu_seq_state_t : sequencer FSM states
//   REG_*           : host address region codes (addr[ADDRW-1:8])
//   rd_sel_t        : host dataOut mux selections
//   region_t        : decoded region reported by tpu_addr_decode
package tpu_pkg;

   typedef enum logic [1:0] {IDLE, MATMUL, DONE} tpu_seq_state_t;

   localparam logic [7:0] REG_A   = 8'h01;
   localparam logic [7:0] REG_B   = 8'h02;
   localparam logic [7:0] REG_C   = 8'h03;
   localparam logic [7:0] REG_CMD = 8'h04;

   typedef enum logic [1:0] {
      RD_ZERO = 2'd0,
      RD_CLO  = 2'd1,
      RD_CHI  = 2'd2,
      RD_STAT = 2'd3
   } rd_sel_t;

   typedef enum logic [2:0] {
      RGN_NONE = 3'd0,
      RGN_A    = 3'd1,
      RGN_B    = 3'd2,
      RGN_C    = 3'd3,
      RGN_CMD  = 3'd4
   } region_t;

endpackage

// File: rtl/tpu_seq_if.sv
// tpu_seq_if: host access bus into the TPU sequencer.
//   req  : access strobe, one access per cycle
//   r_w  : 0 = read, 1 = write
//   addr : host byte address
// master = host side (drives), slave = sequencer side (receives).
interface tpu_seq_if #(
   parameter int unsigned ADDRW = 16
);

   logic             req;
   logic             r_w;
   logic [ADDRW-1:0] addr;

   modport master (output req, output r_w, output addr);
   modport slave  (input  req, input  r_w, input  addr);

endinterface

// File: rtl/tpu_addr_decode.sv
// tpu_addr_decode: purely combinational host address decode.
//   addr   : host byte address
//   region : region selected by addr[ADDRW-1:8]
//   row_a  : memA row, addr[$clog2(DIM)+2:3] (one 64-bit word per A row)
//   row_c  : C row,    addr[$clog2(DIM)+3:4] (two 64-bit words per C row)
//   half   : C half-row select, addr[3]
module tpu_addr_decode
   import tpu_pkg::*;
#(
   parameter int unsigned DIM   = 8,
   parameter int unsigned ADDRW = 16
) (
   input  logic [ADDRW-1:0]        addr,
   output region_t                 region,
   output logic [$clog2(DIM)-1:0]  row_a,
   output logic [$clog2(DIM)-1:0]  row_c,
   output logic                    half
);

   localparam int unsigned RW = $clog2(DIM);
   localparam int unsigned PW = ADDRW - 8;

   logic [PW-1:0] page;
   logic          unused_low;

   assign page  = addr[ADDRW-1:8];
   assign row_a = addr[RW+2:3];
   assign row_c = addr[RW+3:4];
   assign half  = addr[3];

   // Byte-lane bits and, for small DIM, high row bits carry no meaning.
   assign unused_low = ^addr[7:0];

   always_comb begin
      region = RGN_NONE;
      if (page == PW'(REG_A)) begin
         region = RGN_A;
      end else if (page == PW'(REG_B)) begin
         region = RGN_B;
      end else if (page == PW'(REG_C)) begin
         region = RGN_C;
      end else if (page == PW'(REG_CMD)) begin
         region = RGN_CMD;
      end
   end

endmodule

// File: rtl/tpu_seq.sv
// tpu_seq: TPU control sequencer.
// Decodes host accesses into memA / memB / systolic_array strobes and runs a
// fixed-length (3*DIM-2 cycle) multiply pass when the command address is written.
//   clk, rst_n       : clock, asynchronous active-low reset
//   host             : host access bus (req, r_w, addr)
//   en_a, en_b       : memA / memB enables
//   en_sys           : systolic_array enable
//   wr_a, wr_c       : memA / systolic_array write enables
//   Arow, Crow       : memA / systolic_array row selects
//   rd_sel           : dataOut mux (zero, C low, C high, status)
//   busy             : pass in progress (MATMUL or DONE)
//   done             : one-cycle pulse at end of pass
//   drop             : access ignored because busy
module tpu_seq
   import tpu_pkg::*;
#(
   parameter int unsigned BITS_AB = 8,
   parameter int unsigned BITS_C  = 16,
   parameter int unsigned DIM     = 8,
   parameter int unsigned ADDRW   = 16,
   parameter int unsigned DATAW   = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   tpu_seq_if.slave               host,
   output logic                   en_a,
   output logic                   en_b,
   output logic                   en_sys,
   output logic                   wr_a,
   output logic                   wr_c,
   output logic [$clog2(DIM)-1:0] Arow,
   output logic [$clog2(DIM)-1:0] Crow,
   output logic [1:0]             rd_sel,
   output logic                   busy,
   output logic                   done,
   output logic                   drop
);

   localparam int unsigned RW   = $clog2(DIM);
   localparam int unsigned CNTW = $clog2(3 * DIM - 1);
   localparam logic [CNTW-1:0] LAST = CNTW'(3 * DIM - 3);

   // Data widths only matter to the datapath outside this block.
   localparam int unsigned unused_widths = BITS_AB + BITS_C + DATAW;

   tpu_seq_state_t  state_q;
   logic [CNTW-1:0] cnt_q;
   logic            busy_q;
   logic            done_q;
   logic            run_q;

   region_t         region;
   logic [RW-1:0]   row_a;
   logic [RW-1:0]   row_c;
   logic            half;
   logic            cmd_wr;

   tpu_addr_decode #(
      .DIM   (DIM),
      .ADDRW (ADDRW)
   ) u_decode (
      .addr   (host.addr),
      .region (region),
      .row_a  (row_a),
      .row_c  (row_c),
      .half   (half)
   );

   assign cmd_wr = host.req && host.r_w && (region == RGN_CMD);

   // FSM with registered status/enable flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cmd_wr) begin
                  state_q <= MATMUL;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  run_q   <= 1'b1;
               end
            end
            MATMUL: begin
               if (cnt_q == LAST) begin
                  state_q <= DONE;
                  run_q   <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNTW'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               run_q   <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;

   // Idle strobes are combinational so a memory write lands on the access edge.
   // Gated by rst_n so every output is quiet while reset is held.
   always_comb begin
      en_a   = 1'b0;
      en_b   = 1'b0;
      en_sys = 1'b0;
      wr_a   = 1'b0;
      wr_c   = 1'b0;
      Arow   = '0;
      Crow   = '0;
      rd_sel = RD_ZERO;
      drop   = 1'b0;
      if (!rst_n) begin
         drop = 1'b0;
      end else if (busy_q) begin
         en_a   = run_q;
         en_b   = run_q;
         en_sys = run_q;
         drop   = host.req;
      end else if (host.req) begin
         unique case (region)
            RGN_A: begin
               if (host.r_w) begin
                  en_a = 1'b1;
                  wr_a = 1'b1;
                  Arow = row_a;
               end
            end
            RGN_B: begin
               en_b = host.r_w;
            end
            RGN_C: begin
               Crow = row_c;
               if (host.r_w) begin
                  wr_c = 1'b1;
               end else begin
                  rd_sel = half ? RD_CHI : RD_CLO;
               end
            end
            RGN_CMD: begin
               if (!host.r_w) begin
                  rd_sel = RD_STAT;
               end
            end
            default: begin
               rd_sel = RD_ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tpu_seq.sv
// tb_tpu_seq: directed scoreboard bench for tpu_seq (DIM = 8).
// The driver issues one access per cycle and queues the hand-computed output
// vector for that cycle; the monitor samples the DUT on the falling edge and
// compares against the head of the queue.
module tb_tpu_seq;
   import tpu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   tpu_seq_if #(.ADDRW(16)) bus ();

   logic       en_a, en_b, en_sys, wr_a, wr_c;
   logic [2:0] Arow, Crow;
   logic [1:0] rd_sel;
   logic       busy, done, drop;

   tpu_seq #(
      .BITS_AB (8),
      .BITS_C  (16),
      .DIM     (8),
      .ADDRW   (16),
      .DATAW   (64)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .host   (bus),
      .en_a   (en_a),
      .en_b   (en_b),
      .en_sys (en_sys),
      .wr_a   (wr_a),
      .wr_c   (wr_c),
      .Arow   (Arow),
      .Crow   (Crow),
      .rd_sel (rd_sel),
      .busy   (busy),
      .done   (done),
      .drop   (drop)
   );

   logic [15:0] dec_addr;
   region_t     dec_region;
   logic [2:0]  dec_row_a, dec_row_c;
   logic        dec_half;

   tpu_addr_decode #(
      .DIM   (8),
      .ADDRW (16)
   ) u_dec (
      .addr   (dec_addr),
      .region (dec_region),
      .row_a  (dec_row_a),
      .row_c  (dec_row_c),
      .half   (dec_half)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_q[$];
   string       name_q[$];
   logic [15:0] obs;

   // {en_a,en_b,en_sys,wr_a,wr_c,Arow,Crow,rd_sel,busy,done,drop}
   assign obs = {en_a, en_b, en_sys, wr_a, wr_c, Arow, Crow, rd_sel, busy, done, drop};

   function automatic logic [15:0] ex(input logic ea, input logic eb, input logic es,
                                      input logic wa, input logic wc,
                                      input logic [2:0] ar, input logic [2:0] cr,
                                      input logic [1:0] rs, input logic bz,
                                      input logic dn, input logic dr);
      return {ea, eb, es, wa, wc, ar, cr, rs, bz, dn, dr};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req_v);
      n_cmp++;
      if (act !== req_v) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req_v);
      end
   endtask

   task automatic dec_chk(input string name, input logic [15:0] a, input region_t r,
                          input logic [2:0] ra, input logic [2:0] rc, input logic h);
      dec_addr = a;
      #1;
      check(name, {6'b0, dec_region, dec_row_a, dec_row_c, dec_half},
            {6'b0, r, ra, rc, h});
   endtask

   task automatic step(input logic rst, input logic rq, input logic rw,
                       input logic [15:0] a, input logic [15:0] e, input string name);
      @(posedge clk);
      #1;
      rst_n    = rst;
      bus.req  = rq;
      bus.r_w  = rw;
      bus.addr = a;
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            check(name_q.pop_front(), obs, exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   initial begin
      logic [15:0] e_run, e_run_drop, e_done, e_done_drop, e_zero;
      e_zero      = 16'h0000;
      e_run       = ex(1, 1, 1, 0, 0, 3'd0, 3'd0, 2'd0, 1, 0, 0);
      e_run_drop  = ex(1, 1, 1, 0, 0, 3'd0, 3'd0, 2'd0, 1, 0, 1);
      e_done      = ex(0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 1, 1, 0);
      e_done_drop = ex(0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 1, 1, 1);

      rst_n    = 1'b0;
      bus.req  = 1'b1;
      bus.r_w  = 1'b1;
      bus.addr = 16'h0400;

      // Shared decoder, hand-decoded addresses
      dec_chk("dec_0118", 16'h0118, RGN_A,    3'd3, 3'd1, 1'b1);
      dec_chk("dec_0338", 16'h0338, RGN_C,    3'd7, 3'd3, 1'b1);
      dec_chk("dec_0405", 16'h0405, RGN_CMD,  3'd0, 3'd0, 1'b0);
      dec_chk("dec_ff38", 16'hFF38, RGN_NONE, 3'd7, 3'd3, 1'b1);

      // Reset held with a CMD write on the bus, then accepted after release
      step(1'b0, 1'b1, 1'b1, 16'h0400, e_zero, "rst_hold0");
      step(1'b0, 1'b1, 1'b1, 16'h0400, e_zero, "rst_hold1");
      step(1'b1, 1'b1, 1'b1, 16'h0400, e_zero, "p1_cmd");
      for (int i = 0; i < 22; i++) begin
         step(1'b1, 1'b0, 1'b0, 16'h0000, e_run, $sformatf("p1_run%0d", i));
      end
      step(1'b1, 1'b0, 1'b0, 16'h0000, e_done, "p1_done");
      step(1'b1, 1'b0, 1'b0, 16'h0000, e_zero, "p1_idle");

      // Idle decode of individual accesses
      step(1'b1, 1'b1, 1'b1, 16'h0118, ex(1, 0, 0, 1, 0, 3'd3, 3'd0, 2'd0, 0, 0, 0), "wr_a_0118");
      step(1'b1, 1'b1, 1'b1, 16'h0200, ex(0, 1, 0, 0, 0, 3'd0, 3'd0, 2'd0, 0, 0, 0), "wr_b_0200");
      step(1'b1, 1'b1, 1'b0, 16'h0338, ex(0, 0, 0, 0, 0, 3'd0, 3'd3, 2'd2, 0, 0, 0), "rd_c_0338");
      step(1'b1, 1'b1, 1'b0, 16'h0330, ex(0, 0, 0, 0, 0, 3'd0, 3'd3, 2'd1, 0, 0, 0), "rd_c_0330");
      step(1'b1, 1'b1, 1'b0, 16'h0400, ex(0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd3, 0, 0, 0), "rd_stat");
      step(1'b1, 1'b1, 1'b1, 16'h0350, ex(0, 0, 0, 0, 1, 3'd0, 3'd5, 2'd0, 0, 0, 0), "wr_c_0350");
      step(1'b1, 1'b1, 1'b1, 16'h013F, ex(1, 0, 0, 1, 0, 3'd7, 3'd0, 2'd0, 0, 0, 0), "wr_a_013f");
      step(1'b1, 1'b1, 1'b0, 16'h0108, e_zero, "rd_a_0108");
      step(1'b1, 1'b1, 1'b0, 16'h0200, e_zero, "rd_b_0200");
      step(1'b1, 1'b1, 1'b1, 16'h0500, e_zero, "wr_unmapped");
      step(1'b1, 1'b1, 1'b0, 16'h0000, e_zero, "rd_unmapped");
      step(1'b1, 1'b0, 1'b1, 16'h0118, e_zero, "no_req");

      // Pass with accesses while busy: all dropped, no retrigger
      step(1'b1, 1'b1, 1'b1, 16'h0400, e_zero, "p2_cmd");
      for (int i = 0; i < 22; i++) begin
         if (i == 3) begin
            step(1'b1, 1'b1, 1'b1, 16'h0100, e_run_drop, "p2_drop_wr_a");
         end else if (i == 4) begin
            step(1'b1, 1'b1, 1'b1, 16'h0400, e_run_drop, "p2_drop_cmd");
         end else if (i == 21) begin
            step(1'b1, 1'b1, 1'b0, 16'h0338, e_run_drop, "p2_drop_last");
         end else begin
            step(1'b1, 1'b0, 1'b0, 16'h0000, e_run, $sformatf("p2_run%0d", i));
         end
      end
      step(1'b1, 1'b1, 1'b1, 16'h0400, e_done_drop, "p2_done_drop");
      step(1'b1, 1'b0, 1'b0, 16'h0000, e_zero, "p2_idle0");
      step(1'b1, 1'b0, 1'b0, 16'h0000, e_zero, "p2_idle1");

      // Reset in the tenth MATMUL cycle abandons the pass silently
      step(1'b1, 1'b1, 1'b1, 16'h0400, e_zero, "p3_cmd");
      for (int i = 0; i < 9; i++) begin
         step(1'b1, 1'b0, 1'b0, 16'h0000, e_run, $sformatf("p3_run%0d", i));
      end
      step(1'b0, 1'b0, 1'b0, 16'h0000, e_zero, "p3_rst_mid");
      step(1'b1, 1'b0, 1'b0, 16'h0000, e_zero, "p3_after_rst0");
      step(1'b1, 1'b0, 1'b0, 16'h0000, e_zero, "p3_after_rst1");

      // Fresh full pass after the interrupted one
      step(1'b1, 1'b1, 1'b1, 16'h0400, e_zero, "p4_cmd");
      for (int i = 0; i < 22; i++) begin
         step(1'b1, 1'b0, 1'b0, 16'h0000, e_run, $sformatf("p4_run%0d", i));
      end
      step(1'b1, 1'b0, 1'b0, 16'h0000, e_done, "p4_done");
      step(1'b1, 1'b0, 1'b0, 16'h0000, e_zero, "p4_idle");

      @(negedge clk);
      #1;
      check("queue_drained", 16'(exp_q.size()), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
